rice_encoder: RTL

//  Rice/Golomb encoder for telemetry samples: the compression end feeding the on-ground Rice decoder.
//  Per sample: quotient q = sample>>k as unary (q '0's then a '1'), then k remainder bits MSB-first.

---
 rtl/rice_pkg.sv | 16 +
 rtl/rice_bit_packer.sv | 102 ++++++++++
 rtl/rice_encoder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/rice_pkg.sv
// Shared constants and state encoding for the Rice/Golomb telemetry encoder.
// Imported by the encoder FSM and its bit packer.
package rice_pkg;

   localparam int unsigned SAMPLE_W = 16;
   localparam int unsigned WORD_W   = 32;
   localparam int unsigned KW       = 5;
   localparam int unsigned ESC_Q    = 24;
   localparam int unsigned K_MAX    = 16;
   localparam int unsigned NBITS_W  = 6;
   localparam int unsigned CNT_W    = 5;
   localparam int unsigned LEN_W    = 5;

   typedef enum logic [1:0] {StIdle, StUnary, StRem, StFlush} rice_state_e;

endpackage

// File: rtl/rice_bit_packer.sv
// Packs single code bits MSB-first into words; a full word moves to a holding register
// so shifting can continue while the consumer is slow.
module rice_bit_packer
   import rice_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                bit_i,
   input  logic                bit_vld_i,
   input  logic                flush_req_i,
   output logic                flush_ack_o,
   output logic                stall_o,
   output logic [WORD_W-1:0]   word_o,
   output logic [NBITS_W-1:0]  nbits_o,
   output logic                last_o,
   output logic                valid_o,
   input  logic                ready_i
);

   localparam logic [NBITS_W-1:0] Full = NBITS_W'(WORD_W);

   logic [WORD_W-1:0]  sr_q, sr_d, shifted;
   logic [NBITS_W-1:0] fill_q, fill_d;
   logic [WORD_W-1:0]  hold_data_q, hold_data_d;
   logic [NBITS_W-1:0] hold_nbits_q, hold_nbits_d;
   logic               hold_last_q, hold_last_d;
   logic               hold_valid_q, hold_valid_d;
   logic               hold_free;

   assign hold_free   = !hold_valid_q || ready_i;
   // fill == Full only when a word completed while the holding register was occupied
   assign stall_o     = (fill_q == Full);
   assign flush_ack_o = flush_req_i && !stall_o && ((fill_q == '0) || hold_free);
   assign shifted     = {sr_q[WORD_W-2:0], bit_i};

   always_comb begin
      sr_d         = sr_q;
      fill_d       = fill_q;
      hold_data_d  = hold_data_q;
      hold_nbits_d = hold_nbits_q;
      hold_last_d  = hold_last_q;
      hold_valid_d = hold_valid_q;
      if (hold_valid_q && ready_i) begin
         hold_valid_d = 1'b0;
      end
      if (stall_o) begin
         if (hold_free) begin
            hold_data_d  = sr_q;
            hold_nbits_d = Full;
            hold_last_d  = 1'b0;
            hold_valid_d = 1'b1;
            fill_d       = '0;
         end
      end else if (bit_vld_i) begin
         sr_d = shifted;
         if (fill_q == Full - NBITS_W'(1)) begin
            if (hold_free) begin
               hold_data_d  = shifted;
               hold_nbits_d = Full;
               hold_last_d  = 1'b0;
               hold_valid_d = 1'b1;
               fill_d       = '0;
            end else begin
               fill_d = Full;
            end
         end else begin
            fill_d = fill_q + NBITS_W'(1);
         end
      end else if (flush_ack_o && (fill_q != '0)) begin
         // Stale bits above the fill count are shifted out, leaving zero padding below
         hold_data_d  = sr_q << (Full - fill_q);
         hold_nbits_d = fill_q;
         hold_last_d  = 1'b1;
         hold_valid_d = 1'b1;
         fill_d       = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sr_q         <= '0;
         fill_q       <= '0;
         hold_data_q  <= '0;
         hold_nbits_q <= '0;
         hold_last_q  <= 1'b0;
         hold_valid_q <= 1'b0;
      end else begin
         sr_q         <= sr_d;
         fill_q       <= fill_d;
         hold_data_q  <= hold_data_d;
         hold_nbits_q <= hold_nbits_d;
         hold_last_q  <= hold_last_d;
         hold_valid_q <= hold_valid_d;
      end
   end

   assign word_o  = hold_data_q;
   assign nbits_o = hold_nbits_q;
   assign last_o  = hold_last_q;
   assign valid_o = hold_valid_q;

endmodule

// File: rtl/rice_encoder.sv
// Rice/Golomb encoder: unary quotient, '1' separator, k remainder bits, with an escape
// to the raw sample for long quotients. One code bit per non-stalled cycle.
module rice_encoder
   import rice_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [SAMPLE_W-1:0] s_data,
   input  logic [KW-1:0]       k,
   input  logic                flush,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [WORD_W-1:0]   m_data,
   output logic [NBITS_W-1:0]  m_nbits,
   output logic                m_last,
   output logic                busy
);

   rice_state_e         state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [LEN_W-1:0]    len_q;
   logic [SAMPLE_W-1:0] val_q;
   logic                flush_pend_q;
   logic                s_ready_q;

   logic                xfer, esc, stall, flush_ack, bit_out, bit_vld;
   logic [KW-1:0]       k_clamp;
   logic [SAMPLE_W-1:0] quo, rem_mask, code_val;
   logic [LEN_W-1:0]    code_len;

   assign xfer = s_valid && s_ready_q;

   always_comb begin
      k_clamp  = (k > KW'(K_MAX)) ? KW'(K_MAX) : k;
      quo      = s_data >> k_clamp;
      rem_mask = SAMPLE_W'((32'd1 << k_clamp) - 32'd1);
      esc      = (quo >= SAMPLE_W'(ESC_Q));
      code_len = esc ? LEN_W'(SAMPLE_W) : LEN_W'(k_clamp);
      // Payload is left-aligned so REM always emits the MSB and shifts left
      code_val = (esc ? s_data : (s_data & rem_mask)) << (LEN_W'(SAMPLE_W) - code_len);
   end

   always_comb begin
      bit_vld = (state_q == StUnary) || (state_q == StRem);
      bit_out = (state_q == StUnary) ? (cnt_q == '0) : val_q[SAMPLE_W-1];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         len_q        <= '0;
         val_q        <= '0;
         flush_pend_q <= 1'b0;
         s_ready_q    <= 1'b0;
      end else begin
         s_ready_q <= 1'b0;
         if (flush) begin
            flush_pend_q <= 1'b1;
         end
         unique case (state_q)
            StIdle: begin
               if (xfer) begin
                  state_q <= StUnary;
                  cnt_q   <= esc ? CNT_W'(ESC_Q) : CNT_W'(quo);
                  len_q   <= code_len;
                  val_q   <= code_val;
               end else if (flush_pend_q) begin
                  state_q <= StFlush;
               end else begin
                  s_ready_q <= !flush;
               end
            end
            StUnary: begin
               if (!stall) begin
                  if (cnt_q != '0) begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end else if (len_q != '0) begin
                     state_q <= StRem;
                  end else begin
                     state_q   <= StIdle;
                     s_ready_q <= !(flush_pend_q || flush);
                  end
               end
            end
            StRem: begin
               if (!stall) begin
                  val_q <= val_q << 1;
                  len_q <= len_q - LEN_W'(1);
                  if (len_q == LEN_W'(1)) begin
                     state_q   <= StIdle;
                     s_ready_q <= !(flush_pend_q || flush);
                  end
               end
            end
            StFlush: begin
               if (flush_ack) begin
                  state_q      <= StIdle;
                  flush_pend_q <= flush;
                  s_ready_q    <= !flush;
               end
            end
         endcase
      end
   end

   rice_bit_packer u_packer (
      .clk_i       (clk),
      .rst_i       (reset),
      .bit_i       (bit_out),
      .bit_vld_i   (bit_vld),
      .flush_req_i (state_q == StFlush),
      .flush_ack_o (flush_ack),
      .stall_o     (stall),
      .word_o      (m_data),
      .nbits_o     (m_nbits),
      .last_o      (m_last),
      .valid_o     (m_valid),
      .ready_i     (m_ready)
   );

   assign s_ready = s_ready_q;
   assign busy    = (state_q != StIdle) || m_valid || flush_pend_q;

endmodule
